// File: rtl/storage_copy_controller.sv
// Word-by-word copy engine between a storage drive and main memory.
// Each word takes a READ cycle (source address out) and a WRITE cycle
// (source read data passed straight through to the destination).
module storage_copy_controller #(
    parameter int unsigned DW             = 32,
    parameter int unsigned HD_ADDR_WIDTH  = 14,
    parameter int unsigned RAM_ADDR_WIDTH = 14
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      direction,
    input  logic [HD_ADDR_WIDTH-1:0]  hd_base,
    input  logic [RAM_ADDR_WIDTH-1:0] ram_base,
    input  logic [HD_ADDR_WIDTH:0]    length,
    input  logic                      abort,
    output logic [HD_ADDR_WIDTH-1:0]  hd_address,
    output logic [DW-1:0]             hd_write_data,
    output logic                      hd_write_enable,
    input  logic [DW-1:0]             hd_read_data,
    output logic [RAM_ADDR_WIDTH-1:0] ram_address,
    output logic [DW-1:0]             ram_write_data,
    output logic                      ram_write_enable,
    input  logic [DW-1:0]             ram_read_data,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e                    state_q, state_d;
    logic                      dir_q, dir_d;      // 0: drive->RAM, 1: RAM->drive
    logic [HD_ADDR_WIDTH-1:0]  hd_ptr_q, hd_ptr_d;
    logic [RAM_ADDR_WIDTH-1:0] ram_ptr_q, ram_ptr_d;
    logic [HD_ADDR_WIDTH:0]    count_q, count_d;

    // State and transfer-parameter registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= StIdle;
            dir_q     <= 1'b0;
            hd_ptr_q  <= '0;
            ram_ptr_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            hd_ptr_q  <= hd_ptr_d;
            ram_ptr_q <= ram_ptr_d;
            count_q   <= count_d;
        end
    end

    // Next-state: latch parameters in idle, advance pointers after each write.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        hd_ptr_d  = hd_ptr_q;
        ram_ptr_d = ram_ptr_q;
        count_d   = count_q;
        unique case (state_q)
            StIdle: begin
                // start wins over abort here; abort is only meaningful when busy
                if (start) begin
                    dir_d     = direction;
                    hd_ptr_d  = hd_base;
                    ram_ptr_d = ram_base;
                    count_d   = length;
                    state_d   = (length != '0) ? StRead : StDone;
                end
            end
            StRead: begin
                state_d = abort ? StIdle : StWrite;
            end
            StWrite: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    // Pointers wrap independently within their own address space
                    hd_ptr_d  = hd_ptr_q + 1'b1;
                    ram_ptr_d = ram_ptr_q + 1'b1;
                    count_d   = count_q - 1'b1;
                    state_d   = (count_q != 1) ? StRead : StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode from registered state; only write data passes through.
    always_comb begin
        hd_address       = '0;
        hd_write_data    = '0;
        hd_write_enable  = 1'b0;
        ram_address      = '0;
        ram_write_data   = '0;
        ram_write_enable = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StRead: begin
                busy = 1'b1;
                if (dir_q) begin
                    ram_address = ram_ptr_q;
                end else begin
                    hd_address = hd_ptr_q;
                end
            end
            StWrite: begin
                busy = 1'b1;
                // abort kills the strobe in the same cycle
                if (dir_q) begin
                    hd_address      = hd_ptr_q;
                    hd_write_data   = ram_read_data;
                    hd_write_enable = ~abort;
                end else begin
                    ram_address      = ram_ptr_q;
                    ram_write_data   = hd_read_data;
                    ram_write_enable = ~abort;
                end
            end
            StDone: begin
                done = 1'b1;
            end
        endcase
    end

endmodule
